// File: rtl/systola_pkg.sv
// rtl/systola_pkg.sv - shared types and defaults for the systolic array output path
package systola_pkg;

  localparam int SYSTOLA_WORDLEN = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } drain_state_t;

endpackage

// File: rtl/outbuf_drain_if.sv
// rtl/outbuf_drain_if.sv - PE column push bus and serialized result stream
interface outbuf_drain_if
  import systola_pkg::*;
#(
  parameter int WORDLEN = SYSTOLA_WORDLEN,
  parameter int NCOLS   = 4
) ();

  logic [NCOLS-1:0]         col_valid;
  logic [NCOLS*WORDLEN-1:0] col_data;
  logic                     out_ready;
  logic                     out_valid;
  logic [WORDLEN-1:0]       out_data;
  logic [$clog2(NCOLS)-1:0] out_col;
  logic                     out_last;

  modport master (
    output col_valid, col_data, out_ready,
    input  out_valid, out_data, out_col, out_last
  );

  modport slave (
    input  col_valid, col_data, out_ready,
    output out_valid, out_data, out_col, out_last
  );

endinterface

// File: rtl/outbuf_lane.sv
// rtl/outbuf_lane.sv - one circular result FIFO lane; a full lane still accepts a push when it pops
module outbuf_lane
  import systola_pkg::*;
#(
  parameter int WORDLEN = SYSTOLA_WORDLEN,
  parameter int DEPTH   = 16
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WORDLEN-1:0]       din,
  output logic [WORDLEN-1:0]       dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  logic [WORDLEN-1:0] mem [DEPTH];
  logic [PW-1:0]      head;
  logic [PW-1:0]      tail;
  logic               do_push;
  logic               do_pop;

  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);
  assign dout  = mem[head];

  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);

  // DEPTH is a power of two, so pointer wrap is the natural binary rollover
  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) tail <= tail + 1'b1;
      if (do_pop)  head <= head + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[tail] <= din;
  end

endmodule

// File: rtl/outbuf_drain.sv
// rtl/outbuf_drain.sv - per-column result FIFOs drained row by row onto one stream; OUTBUF_RELU_EN clamps negative words to 0
module outbuf_drain
  import systola_pkg::*;
#(
  parameter int WORDLEN = SYSTOLA_WORDLEN,
  parameter int NCOLS   = 4,
  parameter int DEPTH   = 16
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           flush,
  output logic           full,
  output logic           overflow,
  outbuf_drain_if.slave  bus
);

  localparam int CW = $clog2(NCOLS);
  localparam logic [CW-1:0] LAST_COL = CW'(NCOLS - 1);

  drain_state_t state;
  drain_state_t state_nxt;
  logic [CW-1:0] col_q;

  logic [WORDLEN-1:0]   lane_dout  [NCOLS];
  logic [$clog2(DEPTH):0] lane_count [NCOLS];
  logic [NCOLS-1:0]     lane_full;
  logic [NCOLS-1:0]     lane_empty;
  logic [NCOLS-1:0]     lane_have;
  logic [NCOLS-1:0]     pop;
  logic [NCOLS-1:0]     drop;
  logic                 row_ready;
  logic                 beat;
  logic [WORDLEN-1:0]   head_word;
  logic [WORDLEN-1:0]   shown_word;

  for (genvar c = 0; c < NCOLS; c++) begin : g_lane
    assign pop[c]       = beat && (col_q == CW'(c)) && !lane_empty[c];
    assign drop[c]      = bus.col_valid[c] && lane_full[c] && !pop[c] && !flush;
    assign lane_have[c] = (lane_count[c] != '0);

    outbuf_lane #(
      .WORDLEN (WORDLEN),
      .DEPTH   (DEPTH)
    ) u_lane (
      .clk   (clk),
      .rstn  (rstn),
      .flush (flush),
      .push  (bus.col_valid[c]),
      .pop   (pop[c]),
      .din   (bus.col_data[c*WORDLEN +: WORDLEN]),
      .dout  (lane_dout[c]),
      .count (lane_count[c]),
      .full  (lane_full[c]),
      .empty (lane_empty[c])
    );
  end

  assign row_ready = &lane_have;
  assign beat      = (state == SEND) && bus.out_ready;
  assign full      = |lane_full;
  assign head_word = lane_dout[col_q];

`ifdef OUTBUF_RELU_EN
  assign shown_word = head_word[WORDLEN-1] ? '0 : head_word;
`else
  assign shown_word = head_word;
`endif

  always_ff @(posedge clk) begin
    if (!rstn || flush) state <= IDLE;
    else                state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (row_ready) state_nxt = SEND;
      SEND: if (bus.out_ready && (col_q == LAST_COL)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.out_valid = 1'b0;
    bus.out_last  = 1'b0;
    bus.out_data  = '0;
    if (state == SEND) begin
      bus.out_valid = 1'b1;
      bus.out_last  = (col_q == LAST_COL);
      bus.out_data  = shown_word;
    end
  end

  // Column index only moves on an accepted beat, so it holds under backpressure
  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      col_q <= '0;
    end else if (state == IDLE) begin
      if (row_ready) col_q <= '0;
    end else if (bus.out_ready && (col_q != LAST_COL)) begin
      col_q <= col_q + 1'b1;
    end
  end

  assign bus.out_col = col_q;

  // Sticky until reset; flush deliberately leaves it alone
  always_ff @(posedge clk) begin
    if (!rstn)       overflow <= 1'b0;
    else if (|drop)  overflow <= 1'b1;
  end

endmodule

// File: tb/tb_outbuf_drain.sv
// tb/tb_outbuf_drain.sv - queue-model bench for outbuf_drain (WORDLEN=8, NCOLS=4, DEPTH=4)
module tb_outbuf_drain;

  localparam int NC = 4;
  localparam int DP = 4;

  logic clk = 1'b0;
  logic rstn;
  logic flush;
  logic full;
  logic overflow;

  outbuf_drain_if #(.WORDLEN(8), .NCOLS(NC)) iface ();

  outbuf_drain #(.WORDLEN(8), .NCOLS(NC), .DEPTH(DP)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .flush    (flush),
    .full     (full),
    .overflow (overflow),
    .bus      (iface.slave)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  bit mon_en = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] relu(input logic [7:0] v);
`ifdef OUTBUF_RELU_EN
    return v[7] ? 8'h00 : v;
`else
    return v;
`endif
  endfunction

  // Transaction-level model: one queue per column plus "row in flight" and its column
  typedef logic [7:0] bq_t[$];
  bq_t mq [NC];
  bit  m_busy;
  int  m_col;
  bit  m_ovf;
  bit  m_all;
  bit  m_pop;
  int  m_sz;

  always @(posedge clk) begin
    if (!rstn || flush) begin
      for (int c = 0; c < NC; c++) mq[c].delete();
      m_busy = 0;
      m_col  = 0;
      if (!rstn) m_ovf = 0;
    end else begin
      m_all = 1;
      for (int c = 0; c < NC; c++) if (mq[c].size() == 0) m_all = 0;
      for (int c = 0; c < NC; c++) begin
        m_pop = m_busy && iface.out_ready && (m_col == c);
        m_sz  = mq[c].size();
        if (m_pop) void'(mq[c].pop_front());
        if (iface.col_valid[c]) begin
          if (m_sz < DP || m_pop) mq[c].push_back(iface.col_data[c*8 +: 8]);
          else m_ovf = 1;
        end
      end
      if (m_busy && iface.out_ready) begin
        if (m_col == NC-1) m_busy = 0;
        else m_col++;
      end else if (!m_busy && m_all) begin
        m_busy = 1;
        m_col  = 0;
      end
    end
  end

  logic [7:0] e_data;
  bit         e_full;
  always @(negedge clk) begin
    if (mon_en) begin
      e_data = 8'h00;
      if (m_busy && mq[m_col].size() > 0) e_data = relu(mq[m_col][0]);
      e_full = 0;
      for (int c = 0; c < NC; c++) if (mq[c].size() == DP) e_full = 1;
      chk("out_valid", 32'(iface.out_valid), 32'(m_busy));
      chk("out_data", 32'(iface.out_data), 32'(e_data));
      chk("out_last", 32'(iface.out_last), 32'(m_busy && m_col == NC-1));
      if (m_busy) chk("out_col", 32'(iface.out_col), 32'(m_col));
      chk("full", 32'(full), 32'(e_full));
      chk("overflow", 32'(overflow), 32'(m_ovf));
    end
  end

  typedef struct {
    int         c;
    logic [7:0] data;
    logic [1:0] col;
    logic       last;
  } rec_t;
  rec_t got[$];

  always @(negedge clk) begin
    if (rstn && !flush && iface.out_valid && iface.out_ready)
      got.push_back('{cyc, iface.out_data, iface.out_col, iface.out_last});
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_row(input string nm, input logic [7:0] d0, d1, d2, d3);
    logic [7:0] e [4];
    e[0] = d0; e[1] = d1; e[2] = d2; e[3] = d3;
    chk({nm, "_count"}, 32'(got.size()), 32'd4);
    for (int i = 0; i < 4 && i < got.size(); i++) begin
      chk({nm, "_data"}, 32'(got[i].data), 32'(e[i]));
      chk({nm, "_col"},  32'(got[i].col),  32'(i));
      chk({nm, "_last"}, 32'(got[i].last), 32'(i == 3));
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    flush = 1'b0;
    iface.col_valid = '0;
    iface.col_data = '0;
    iface.out_ready = 1'b0;
    tick(2);
    chk("rst_out_valid", 32'(iface.out_valid), 32'd0);
    chk("rst_out_data", 32'(iface.out_data), 32'd0);
    chk("rst_out_col", 32'(iface.out_col), 32'd0);
    chk("rst_out_last", 32'(iface.out_last), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    rstn = 1'b1;
    got.delete();
  endtask

  int c0;
  bit hit;

  initial begin
    rstn = 1'b0;
    flush = 1'b0;
    iface.col_valid = '0;
    iface.col_data = '0;
    iface.out_ready = 1'b0;
    tick(1);
    mon_en = 1;

    // Single-cycle row, ready held high: latency 2, four back-to-back beats
    do_reset();
    iface.out_ready = 1'b1;
    iface.col_data = {8'h44, 8'h33, 8'h22, 8'h11};
    iface.col_valid = 4'hF;
    c0 = cyc;
    tick();
    iface.col_valid = '0;
    chk("t1_bubble_valid", 32'(iface.out_valid), 32'd0);
    tick(6);
    chk_row("t1", 8'h11, 8'h22, 8'h33, 8'h44);
    if (got.size() == 4) begin
      chk("t1_first_cycle", 32'(got[0].c), 32'(c0 + 2));
      chk("t1_last_cycle", 32'(got[3].c), 32'(c0 + 5));
    end

    // Skewed pushes with ready toggling
    do_reset();
    iface.col_data = {8'h53, 8'h52, 8'h51, 8'h50};
    for (int i = 0; i < 16; i++) begin
      iface.col_valid = (i < 4) ? 4'(1 << i) : 4'h0;
      iface.out_ready = (i % 2 == 0);
      tick();
    end
    iface.col_valid = '0;
    chk_row("t2", 8'h50, 8'h51, 8'h52, 8'h53);

    // Overfill lane 0 with downstream stalled
    do_reset();
    for (int i = 0; i < 5; i++) begin
      iface.col_valid = 4'h1;
      iface.col_data = {24'h0, 8'(8'hA0 + i)};
      tick();
      if (i == 3) begin
        chk("t3_full_after4", 32'(full), 32'd1);
        chk("t3_ovf_after4", 32'(overflow), 32'd0);
      end
    end
    iface.col_valid = '0;
    chk("t3_ovf_after5", 32'(overflow), 32'd1);
    chk("t3_model_lane0", 32'(mq[0].size()), 32'd4);
    iface.col_valid = 4'hE;
    iface.col_data = {8'hB3, 8'hB2, 8'hB1, 8'h00};
    iface.out_ready = 1'b1;
    tick();
    iface.col_valid = '0;
    tick(6);
    chk_row("t3", 8'hA0, 8'hB1, 8'hB2, 8'hB3);
    chk("t3_ovf_sticky", 32'(overflow), 32'd1);

    // Full lane 0 being popped accepts a same-cycle push
    do_reset();
    for (int r = 0; r < 4; r++) begin
      iface.col_valid = 4'hF;
      for (int c = 0; c < NC; c++) iface.col_data[c*8 +: 8] = 8'(8'h10 * (r + 1) + c);
      tick();
    end
    chk("t4_full", 32'(full), 32'd1);
    got.delete();
    iface.out_ready = 1'b1;
    iface.col_valid = 4'h1;
    iface.col_data = {24'h0, 8'hEE};
    tick();
    iface.col_valid = '0;
    chk("t4_ovf", 32'(overflow), 32'd0);
    tick(24);
    chk("t4_words", 32'(got.size()), 32'd16);
    if (got.size() == 16) begin
      chk("t4_first", 32'(got[0].data), 32'h10);
      chk("t4_last", 32'(got[15].data), 32'h43);
    end
    got.delete();
    iface.col_valid = 4'hE;
    iface.col_data = {8'hF3, 8'hF2, 8'hF1, 8'h00};
    tick();
    iface.col_valid = '0;
    tick(6);
    chk_row("t4", 8'hEE, 8'hF1, 8'hF2, 8'hF3);

    // Flush mid-row: overflow kept, aborted row not resumed
    do_reset();
    for (int r = 0; r < 5; r++) begin
      iface.col_valid = 4'hF;
      iface.col_data = {4{8'(8'h60 + r)}};
      tick();
    end
    iface.col_valid = '0;
    chk("t5_ovf_set", 32'(overflow), 32'd1);
    iface.out_ready = 1'b1;
    hit = 0;
    for (int i = 0; i < 10 && !hit; i++) begin
      if (iface.out_valid && iface.out_col == 2'd2) hit = 1;
      else tick();
    end
    chk("t5_reached_col2", 32'(hit), 32'd1);
    flush = 1'b1;
    iface.col_valid = 4'hF;
    tick();
    flush = 1'b0;
    iface.col_valid = '0;
    got.delete();
    chk("t5_valid_after", 32'(iface.out_valid), 32'd0);
    chk("t5_full_after", 32'(full), 32'd0);
    chk("t5_ovf_kept", 32'(overflow), 32'd1);
    tick(3);
    chk("t5_idle_words", 32'(got.size()), 32'd0);
    iface.col_valid = 4'hF;
    iface.col_data = {8'hC3, 8'hC2, 8'hC1, 8'hC0};
    tick();
    iface.col_valid = '0;
    tick(6);
    chk_row("t5", 8'hC0, 8'hC1, 8'hC2, 8'hC3);

    // Sign handling on out_data
    do_reset();
    iface.out_ready = 1'b1;
    iface.col_valid = 4'hF;
    iface.col_data = {8'h01, 8'hFF, 8'h7F, 8'h80};
    tick();
    iface.col_valid = '0;
    tick(6);
`ifdef OUTBUF_RELU_EN
    chk_row("t6", 8'h00, 8'h7F, 8'h00, 8'h01);
`else
    chk_row("t6", 8'h80, 8'h7F, 8'hFF, 8'h01);
`endif

    // Reset mid-row aborts it
    iface.col_valid = 4'hF;
    iface.col_data = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
    tick(3);
    iface.col_valid = '0;
    do_reset();
    tick(4);
    chk("t7_no_resume", 32'(got.size()), 32'd0);

    mon_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/outbuf_drain.md
OUTBUF_DRAIN -- requirements
Module: outbuf_drain

Interface
REQ-001 SHALL have parameter WORDLEN, default 8, the result word width in bits.
REQ-002 SHALL have parameter NCOLS, default 4, the number of PE-array result columns (lanes).
REQ-003 SHALL have parameter DEPTH, default 16, the words per lane FIFO (power of two, 2..32).
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rstn  input  1  reset, synchronous, active-low.
REQ-006 col_valid  input  NCOLS  per-column push strobe from the PE array.
REQ-007 col_data  input  NCOLS*WORDLEN  per-column result words, column c at bits [c*WORDLEN +: WORDLEN].
REQ-008 flush  input  1  synchronous clear of all lanes and the serializer.
REQ-009 out_ready  input  1  downstream accepts out_data this cycle.
REQ-010 out_valid  output  1  out_data holds a valid word.
REQ-011 out_data  output  WORDLEN  serialized result word.
REQ-012 out_col  output  $clog2(NCOLS)  column index of out_data.
REQ-013 out_last  output  1  out_data is the last column of a row.
REQ-014 full  output  1  OR of all lane-full flags.
REQ-015 overflow  output  1  sticky flag: a push was dropped.

Function
REQ-016 Each lane SHALL be a circular FIFO with head/tail pointers wrapping from DEPTH-1 to 0, and a count of 0..DEPTH.
REQ-017 A push to lane c (col_valid[c]=1) SHALL be accepted if count<DEPTH, or if count==DEPTH and lane c pops in the same cycle; otherwise the word is dropped and overflow is set.
REQ-018 A pushed word SHALL be visible at the lane head one cycle after the push.
REQ-019 The serializer FSM SHALL have states IDLE and SEND.
REQ-020 IDLE->SEND SHALL occur when every lane count is nonzero; out_col SHALL then be loaded with 0.
REQ-021 In SEND, out_valid=1, out_data=head of lane out_col, and out_last=(out_col==NCOLS-1).
REQ-022 On out_valid&&out_ready, lane out_col SHALL pop; if out_last, the FSM SHALL return to IDLE, otherwise out_col SHALL increment.
REQ-023 Without out_ready, out_data and out_col SHALL hold stable.
REQ-024 Minimum latency: a row whose last lane is pushed at cycle t SHALL present out_valid at t+2, with one IDLE bubble cycle between rows.
REQ-025 In IDLE, out_valid=0, out_data=0, and out_last=0.
REQ-026 flush SHALL zero all pointers and counts, force IDLE, and set out_col=0 at the next edge.
REQ-027 flush SHALL override same-cycle pushes and pops and SHALL NOT clear overflow.
REQ-028 An in-progress row aborted by flush SHALL NOT be resumed.

Reset
REQ-029 When rstn=0 at an edge: out_valid=0, out_data=0, out_col=0, out_last=0, full=0, overflow=0, all lanes empty, FSM=IDLE.
REQ-030 Reset SHALL take priority over flush, push, and pop, and SHALL abort any row mid-transfer.
REQ-031 Lane storage contents SHALL NOT require reset.

Configuration
REQ-032 With OUTBUF_RELU_EN defined, out_data SHALL be 0 whenever the signed head word is negative (MSB=1), else the head word.
REQ-033 Without OUTBUF_RELU_EN, out_data SHALL be the raw head word.
REQ-034 Stored lane data SHALL be unaffected by OUTBUF_RELU_EN in either case.

Structure
REQ-035 Package systola_pkg SHALL hold the FSM state enum (IDLE, SEND) and the default WORDLEN constant.
REQ-036 The per-lane FIFO SHALL be sub-module outbuf_lane (ports: push, pop, din, dout, count, full, empty), instantiated NCOLS times.

Verification (WORDLEN=8, NCOLS=4, DEPTH=4)
REQ-037 Push 0x11,0x22,0x33,0x44 on cols 0..3 in one cycle, out_ready=1 -> out_valid at +2; out_data 0x11,0x22,0x33,0x44 on consecutive cycles, out_col 0..3, out_last only on 0x44.
REQ-038 Skewed push (col c at cycle c), out_ready toggling 1,0 -> row emitted in order, data held while out_ready=0, no word lost.
REQ-039 Five pushes to col 0 with out_ready=0 -> full=1 after the 4th push, overflow=1 after the 5th, lane 0 holds the first four words.
REQ-040 Lane full with FSM popping col 0 and a same-cycle push to col 0 -> push accepted, overflow stays 0.
REQ-041 flush asserted while out_col=2 -> next cycle out_valid=0, all lanes empty, overflow unchanged; a later full row is emitted from col 0.
REQ-042 With OUTBUF_RELU_EN, row 0x80,0x7F,0xFF,0x01 -> out_data 0x00,0x7F,0x00,0x01; without it, raw values.
